vga_text_renderer: RTL and testbench
====================================

Name: vga_text_renderer

Overview:
Pixel pipeline between the VGA sync generator and the vga_port pins of the Nios II system. It turns the current pixel coordinate into a character cell, reads the character code from text VRAM, and looks up the glyph row in the font ROM. It then emits 4-bit RGB aligned with delayed hsync/vsync. It also applies per-character inverse video and a blinking underline cursor.

Parameters:
COLS, 80, characters per text row
ROWS, 30, text rows (16-pixel cells)
BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
pix_en  in  1  pixel strobe, one clk in every two; the pipeline advances only when high
draw_x  in  10  current pixel column from the sync generator
draw_y  in  10  current pixel row from the sync generator
hs_in  in  1  hsync from the sync generator, active low
vs_in  in  1  vsync from the sync generator, active low
blank_in  in  1  1 = inside the visible region
vram_addr  out  10  VRAM word address; each word holds 4 characters
vram_rdata  in  32  VRAM read data, valid 1 clk after vram_addr
font_addr  out  11  {char_code[6:0], glyph_row[3:0]}
font_data  in  8  glyph row, valid 1 clk after font_addr; bit7 = leftmost pixel
fg_color  in  12  {R,G,B} 4 bits each, from the control register
bg_color  in  12  same format
cursor_en  in  1  cursor display enable
cursor_idx  in  12  cursor cell index, row*COLS+col
vga_red  out  4  pixel red
vga_green  out  4  pixel green
vga_blue  out  4  pixel blue
vga_hs  out  1  delayed hsync
vga_vs  out  1  delayed vsync

Behaviour:
- Reset values: vga_red, vga_green, vga_blue = 0; vga_hs = vga_vs = 1; vram_addr = 0; font_addr = 0; blink counter = 0; blink phase = 0; all pipeline valid/blank bits = 0.
- Cell arithmetic:
  - col = draw_x[9:3]; row = draw_y[8:4]; gy = draw_y[3:0]; gx = draw_x[2:0].
  - idx = row*COLS + col, 12 bits, maximum 2399.
  - vram_addr = idx[11:2]; byte select = idx[1:0]; byte 0 = vram_rdata[7:0].
- In-range test: draw_x < 640 and draw_y < 480. Out-of-range pixels force vram_addr = 0 and output black.
- Pipeline stages, each advancing on pix_en:
  - S0: register idx, gx, gy, in-range flag, blank, hs, vs; drive vram_addr.
  - S1: select char byte. Bit7 = inverse, bits[6:0] = code. Drive font_addr = {code, gy}.
  - S2: pixel bit = font_data[7-gx].
    - Cursor hit = cursor_en & blink_phase & (idx == cursor_idx) & (gy >= 14); a hit forces the bit to 1.
    - Inverse XORs the bit.
  - S3 (output register):
    - If blank or out of range: RGB = 0.
    - Otherwise RGB = bit ? fg_color : bg_color.
    - vga_hs and vga_vs take the S2-delayed hs and vs.
- Latency: exactly 3 pix_en strobes from draw_x/draw_y/hs_in/vs_in to the outputs. Sync and colour stay aligned.
- When pix_en = 0, every pipeline register and output holds its value.
- Blink: the counter increments on each vs_in falling edge, detected with a registered copy of vs_in.
  - At BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - With cursor_en = 0 the counter still runs.
- Cursor and inverse on the same cell: cursor forces 1, then inverse applies, so the underline rows show bg_color.
- cursor_idx >= 2400: never matches, so no cursor is drawn.
- fg_color, bg_color and cursor_idx are sampled at S2/S3, so a change takes effect within 1 pixel.
- Reset asserted mid-frame: all state returns to reset values on the next clk. The first valid colour appears 3 pix_en strobes after reset deasserts.

Test Plan:
- VRAM word 0 = 0x00004100, font ROM 'A' row 0 = 0x18, fg = 0xFFF, bg = 0x000; scan (x=8..15, y=0) -> vram_addr = 0, font_addr = 0x410, output pixels 0,0,0,F,F,0,0,0 (per channel) 3 strobes after each input pixel.
- Cell (col 79, row 29): idx = 2399 -> vram_addr = 599, byte select 3. x = 640 or y = 480 -> RGB = 0, vram_addr = 0.
- Character byte 0xC1 (inverse 'A') -> pattern complemented: bg where glyph = 1, fg elsewhere.
- cursor_en = 1, cursor_idx = 5, run 30 vs falling edges -> rows 14-15 of cell 5 turn fg; after 30 more -> off. cursor_idx = 2400 -> never drawn.
- hs_in pulse of 96 pixels -> vga_hs pulse of 96 pixels delayed 3 strobes; pix_en held low 10 clk -> outputs frozen.
- Assert reset mid-line -> RGB = 0, hs = vs = 1, blink counter = 0 on the next clk; colour resumes 3 strobes after release.

Source files
------------

// File: rtl/vga_text_renderer_if.sv
// Memory-side bus of the text renderer: text VRAM and font ROM read ports.
//   vram_addr  : VRAM word address (4 characters per word)
//   vram_rdata : VRAM read data, valid 1 clk after vram_addr
//   font_addr  : {char_code[6:0], glyph_row[3:0]}
//   font_data  : glyph row, valid 1 clk after font_addr, bit7 = leftmost pixel
interface vga_text_renderer_if;
  logic [9:0]  vram_addr;
  logic [31:0] vram_rdata;
  logic [10:0] font_addr;
  logic [7:0]  font_data;

  // Renderer side drives addresses, receives read data.
  modport master (
    output vram_addr,
    output font_addr,
    input  vram_rdata,
    input  font_data
  );

  // Memory side answers the renderer.
  modport slave (
    input  vram_addr,
    input  font_addr,
    output vram_rdata,
    output font_data
  );
endinterface

// File: rtl/vga_text_renderer.sv
// Text-mode pixel pipeline: pixel coordinate -> character cell -> VRAM char
// -> font glyph row -> 4-bit RGB, with inverse video and blinking cursor.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   pix_en              : pixel strobe, pipeline advances only when high
//   draw_x, draw_y      : current pixel coordinate
//   hs_in, vs_in        : active-low syncs from the sync generator
//   blank_in            : 1 = visible region
//   mem                 : VRAM / font ROM read bus (master side)
//   fg_color, bg_color  : {R,G,B} colours
//   cursor_en, cursor_idx : cursor enable and cell index (row*COLS+col)
//   vga_red/green/blue  : pixel colour, 3 strobes after the coordinate
//   vga_hs, vga_vs      : syncs delayed to match the colour
module vga_text_renderer #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_en,
  input  logic [9:0]               draw_x,
  input  logic [9:0]               draw_y,
  input  logic                     hs_in,
  input  logic                     vs_in,
  input  logic                     blank_in,
  vga_text_renderer_if.master      mem,
  input  logic [11:0]              fg_color,
  input  logic [11:0]              bg_color,
  input  logic                     cursor_en,
  input  logic [11:0]              cursor_idx,
  output logic [3:0]               vga_red,
  output logic [3:0]               vga_green,
  output logic [3:0]               vga_blue,
  output logic                     vga_hs,
  output logic                     vga_vs
);

  localparam int unsigned H_PIX = COLS * 8;
  localparam int unsigned V_PIX = ROWS * 16;
  localparam int unsigned BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Stage S0: cell position and sync/blank capture
  logic [11:0]   s0_idx_q,   s0_idx_d;
  logic [2:0]    s0_gx_q,    s0_gx_d;
  logic [3:0]    s0_gy_q,    s0_gy_d;
  logic          s0_inr_q,   s0_inr_d;
  logic          s0_blank_q, s0_blank_d;
  logic          s0_hs_q,    s0_hs_d;
  logic          s0_vs_q,    s0_vs_d;
  logic [9:0]    vram_addr_q, vram_addr_d;

  // Stage S1: character byte decoded, font lookup issued
  logic [11:0]   s1_idx_q,   s1_idx_d;
  logic [2:0]    s1_gx_q,    s1_gx_d;
  logic [3:0]    s1_gy_q,    s1_gy_d;
  logic          s1_inr_q,   s1_inr_d;
  logic          s1_blank_q, s1_blank_d;
  logic          s1_hs_q,    s1_hs_d;
  logic          s1_vs_q,    s1_vs_d;
  logic          s1_inv_q,   s1_inv_d;
  logic [10:0]   font_addr_q, font_addr_d;

  // Output register
  logic [11:0]   rgb_q,      rgb_d;
  logic          hs_out_q,   hs_out_d;
  logic          vs_out_q,   vs_out_d;

  // Cursor blink
  logic          vs_prev_q,     vs_prev_d;
  logic [BW-1:0] blink_cnt_q,   blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  logic [11:0]   idx_c;
  logic          in_range_c;
  logic [7:0]    char_byte_c;
  logic          cursor_hit_c;
  logic          pix_bit_c;

  // Next-state logic for every register; all pipeline state holds without pix_en
  always_comb begin
    s0_idx_d      = s0_idx_q;
    s0_gx_d       = s0_gx_q;
    s0_gy_d       = s0_gy_q;
    s0_inr_d      = s0_inr_q;
    s0_blank_d    = s0_blank_q;
    s0_hs_d       = s0_hs_q;
    s0_vs_d       = s0_vs_q;
    vram_addr_d   = vram_addr_q;
    s1_idx_d      = s1_idx_q;
    s1_gx_d       = s1_gx_q;
    s1_gy_d       = s1_gy_q;
    s1_inr_d      = s1_inr_q;
    s1_blank_d    = s1_blank_q;
    s1_hs_d       = s1_hs_q;
    s1_vs_d       = s1_vs_q;
    s1_inv_d      = s1_inv_q;
    font_addr_d   = font_addr_q;
    rgb_d         = rgb_q;
    hs_out_d      = hs_out_q;
    vs_out_d      = vs_out_q;
    vs_prev_d     = vs_in;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    idx_c      = 12'(draw_y[8:4]) * 12'(COLS) + 12'(draw_x[9:3]);
    in_range_c = (draw_x < 10'(H_PIX)) && (draw_y < 10'(V_PIX));

    // Byte lane of the 4-character VRAM word selected by idx[1:0]
    case (s0_idx_q[1:0])
      2'd0:    char_byte_c = mem.vram_rdata[7:0];
      2'd1:    char_byte_c = mem.vram_rdata[15:8];
      2'd2:    char_byte_c = mem.vram_rdata[23:16];
      default: char_byte_c = mem.vram_rdata[31:24];
    endcase

    // S2 is combinational into the output register; 7-gx == ~gx for 3 bits
    cursor_hit_c = cursor_en && blink_phase_q && (s1_idx_q == cursor_idx) &&
                   (s1_gy_q >= 4'd14);
    pix_bit_c    = (mem.font_data[~s1_gx_q] | cursor_hit_c) ^ s1_inv_q;

    if (pix_en) begin
      s0_idx_d    = idx_c;
      s0_gx_d     = draw_x[2:0];
      s0_gy_d     = draw_y[3:0];
      s0_inr_d    = in_range_c;
      s0_blank_d  = blank_in;
      s0_hs_d     = hs_in;
      s0_vs_d     = vs_in;
      vram_addr_d = in_range_c ? idx_c[11:2] : 10'd0;

      s1_idx_d    = s0_idx_q;
      s1_gx_d     = s0_gx_q;
      s1_gy_d     = s0_gy_q;
      s1_inr_d    = s0_inr_q;
      s1_blank_d  = s0_blank_q;
      s1_hs_d     = s0_hs_q;
      s1_vs_d     = s0_vs_q;
      s1_inv_d    = char_byte_c[7];
      font_addr_d = {char_byte_c[6:0], s0_gy_q};

      // blank_in is 1 inside the visible region
      if (!s1_blank_q || !s1_inr_q) begin
        rgb_d = 12'd0;
      end else begin
        rgb_d = pix_bit_c ? fg_color : bg_color;
      end
      hs_out_d = s1_hs_q;
      vs_out_d = s1_vs_q;
    end

    // Frame counter runs every clk on vsync falling edges, independent of cursor_en
    if (vs_prev_q && !vs_in) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_idx_q      <= '0;
      s0_gx_q       <= '0;
      s0_gy_q       <= '0;
      s0_inr_q      <= 1'b0;
      s0_blank_q    <= 1'b0;
      s0_hs_q       <= 1'b1;
      s0_vs_q       <= 1'b1;
      vram_addr_q   <= '0;
      s1_idx_q      <= '0;
      s1_gx_q       <= '0;
      s1_gy_q       <= '0;
      s1_inr_q      <= 1'b0;
      s1_blank_q    <= 1'b0;
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      s1_inv_q      <= 1'b0;
      font_addr_q   <= '0;
      rgb_q         <= '0;
      hs_out_q      <= 1'b1;
      vs_out_q      <= 1'b1;
      vs_prev_q     <= 1'b1;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      s0_idx_q      <= s0_idx_d;
      s0_gx_q       <= s0_gx_d;
      s0_gy_q       <= s0_gy_d;
      s0_inr_q      <= s0_inr_d;
      s0_blank_q    <= s0_blank_d;
      s0_hs_q       <= s0_hs_d;
      s0_vs_q       <= s0_vs_d;
      vram_addr_q   <= vram_addr_d;
      s1_idx_q      <= s1_idx_d;
      s1_gx_q       <= s1_gx_d;
      s1_gy_q       <= s1_gy_d;
      s1_inr_q      <= s1_inr_d;
      s1_blank_q    <= s1_blank_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_inv_q      <= s1_inv_d;
      font_addr_q   <= font_addr_d;
      rgb_q         <= rgb_d;
      hs_out_q      <= hs_out_d;
      vs_out_q      <= vs_out_d;
      vs_prev_q     <= vs_prev_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign mem.vram_addr = vram_addr_q;
  assign mem.font_addr = font_addr_q;
  assign vga_red       = rgb_q[11:8];
  assign vga_green     = rgb_q[7:4];
  assign vga_blue      = rgb_q[3:0];
  assign vga_hs        = hs_out_q;
  assign vga_vs        = vs_out_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer with behavioural VRAM and font ROM.
module tb_vga_text_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [9:0]  draw_x, draw_y;
  logic        hs_in, vs_in, blank_in;
  logic [11:0] fg_color, bg_color;
  logic        cursor_en;
  logic [11:0] cursor_idx;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic        vga_hs, vga_vs;
  logic [11:0] rgb_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] vram [0:1023];
  logic [7:0]  font [0:2047];

  vga_text_renderer_if mif ();

  vga_text_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .blank_in   (blank_in),
    .mem        (mif.master),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .cursor_en  (cursor_en),
    .cursor_idx (cursor_idx),
    .vga_red    (vga_red),
    .vga_green  (vga_green),
    .vga_blue   (vga_blue),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs)
  );

  always #10 clk = ~clk;

  assign rgb_o = {vga_red, vga_green, vga_blue};

  // Synchronous memories: data valid one clk after the address
  always @(posedge clk) begin
    mif.vram_rdata <= vram[mif.vram_addr];
    mif.font_data  <= font[mif.font_addr];
  end

  // One pixel strobe followed by one idle clk
  task automatic step(input int x, input int y, input logic hs, input logic vs,
                      input logic bl);
    @(negedge clk);
    draw_x   = 10'(x);
    draw_y   = 10'(y);
    hs_in    = hs;
    vs_in    = vs;
    blank_in = bl;
    pix_en   = 1'b1;
    @(negedge clk);
    pix_en   = 1'b0;
  endtask

  // Render one visible pixel and return its colour after the pipeline latency
  task automatic probe(input int x, input int y, output logic [11:0] c);
    step(x, y, 1'b1, 1'b1, 1'b1);
    step(0, 0, 1'b1, 1'b1, 1'b1);
    step(0, 0, 1'b1, 1'b1, 1'b1);
    c = rgb_o;
  endtask

  task automatic vs_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vs_in = 1'b0;
      @(negedge clk);
      vs_in = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rgb_o !== 12'h000 || vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
      errors++;
      $display("FAIL reset_out: rgb=%h hs=%b vs=%b, want rgb=000 hs=1 vs=1", rgb_o, vga_hs, vga_vs);
    end
    checks++;
    if (mif.vram_addr !== 10'd0 || mif.font_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_addr: vram_addr=%0d font_addr=%h, want 0 0", mif.vram_addr, mif.font_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_glyph();
    logic [11:0] exp [8] = '{12'h000, 12'h000, 12'h000, 12'hFFF,
                             12'hFFF, 12'h000, 12'h000, 12'h000};
    fg_color = 12'hFFF;
    bg_color = 12'h000;
    for (int i = 0; i < 10; i++) begin
      step(8 + i, 0, 1'b1, 1'b1, 1'b1);
      if (i == 0) begin
        checks++;
        if (mif.vram_addr !== 10'd0) begin
          errors++;
          $display("FAIL glyph_vram_addr: got %0d want 0", mif.vram_addr);
        end
      end
      if (i == 1) begin
        checks++;
        if (mif.font_addr !== 11'h410) begin
          errors++;
          $display("FAIL glyph_font_addr: got %h want 410", mif.font_addr);
        end
      end
      if (i >= 2) begin
        checks++;
        if (rgb_o !== exp[i-2]) begin
          errors++;
          $display("FAIL glyph_px%0d: got %h want %h", i - 2, rgb_o, exp[i-2]);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int          xs [8] = '{635, 640, 0,   635, 639, 635, 0, 0};
    int          ys [8] = '{464, 464, 480, 464, 479, 464, 0, 0};
    logic        bl [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [9:0]  ea [8] = '{10'd599, 10'd0, 10'd0, 10'd599, 10'd599, 10'd599, 10'd0, 10'd0};
    logic [11:0] ec [6] = '{12'hA5C, 12'h000, 12'h000, 12'hA5C, 12'h123, 12'h000};
    fg_color = 12'hA5C;
    bg_color = 12'h123;
    for (int j = 0; j < 8; j++) begin
      step(xs[j], ys[j], 1'b1, 1'b1, bl[j]);
      checks++;
      if (mif.vram_addr !== ea[j]) begin
        errors++;
        $display("FAIL bound_addr%0d: got %0d want %0d", j, mif.vram_addr, ea[j]);
      end
      if (j >= 2) begin
        checks++;
        if (rgb_o !== ec[j-2]) begin
          errors++;
          $display("FAIL bound_rgb%0d: got %h want %h", j - 2, rgb_o, ec[j-2]);
        end
      end
    end
  endtask

  task automatic test_inverse();
    logic [11:0] exp [8] = '{12'hA5C, 12'hA5C, 12'hA5C, 12'h123,
                             12'h123, 12'hA5C, 12'hA5C, 12'hA5C};
    for (int i = 0; i < 10; i++) begin
      step(32 + i, 0, 1'b1, 1'b1, 1'b1);
      if (i == 1) begin
        checks++;
        if (mif.font_addr !== 11'h410) begin
          errors++;
          $display("FAIL inv_font_addr: got %h want 410", mif.font_addr);
        end
      end
      if (i >= 2) begin
        checks++;
        if (rgb_o !== exp[i-2]) begin
          errors++;
          $display("FAIL inv_px%0d: got %h want %h", i - 2, rgb_o, exp[i-2]);
        end
      end
    end
  endtask

  task automatic test_cursor();
    logic [11:0] c;
    cursor_en  = 1'b1;
    cursor_idx = 12'd5;
    probe(42, 14, c);
    checks++; if (c !== 12'h123) begin errors++; $display("FAIL cur_initial_off: got %h want 123", c); end
    vs_edges(29);
    probe(42, 14, c);
    checks++; if (c !== 12'h123) begin errors++; $display("FAIL cur_29_off: got %h want 123", c); end
    vs_edges(1);
    probe(42, 14, c);
    checks++; if (c !== 12'hA5C) begin errors++; $display("FAIL cur_on_row14: got %h want A5C", c); end
    probe(42, 15, c);
    checks++; if (c !== 12'hA5C) begin errors++; $display("FAIL cur_on_row15: got %h want A5C", c); end
    probe(42, 13, c);
    checks++; if (c !== 12'h123) begin errors++; $display("FAIL cur_row13: got %h want 123", c); end
    probe(48, 14, c);
    checks++; if (c !== 12'h123) begin errors++; $display("FAIL cur_next_cell: got %h want 123", c); end
    cursor_idx = 12'd4;
    probe(32, 14, c);
    checks++; if (c !== 12'h123) begin errors++; $display("FAIL cur_inverse: got %h want 123", c); end
    probe(32, 13, c);
    checks++; if (c !== 12'hA5C) begin errors++; $display("FAIL cur_inverse_row13: got %h want A5C", c); end
    cursor_idx = 12'd5;
    cursor_en  = 1'b0;
    probe(42, 14, c);
    checks++; if (c !== 12'h123) begin errors++; $display("FAIL cur_disabled: got %h want 123", c); end
    cursor_en = 1'b1;
    vs_edges(30);
    probe(42, 14, c);
    checks++; if (c !== 12'h123) begin errors++; $display("FAIL cur_off_again: got %h want 123", c); end
    vs_edges(30);
    cursor_idx = 12'd2400;
    probe(42, 14, c);
    checks++; if (c !== 12'h123) begin errors++; $display("FAIL cur_idx2400: got %h want 123", c); end
    cursor_idx = 12'd5;
    probe(42, 14, c);
    checks++; if (c !== 12'hA5C) begin errors++; $display("FAIL cur_on_again: got %h want A5C", c); end
  endtask

  task automatic test_freeze();
    step(635, 464, 1'b1, 1'b1, 1'b1);
    step(636, 464, 1'b1, 1'b1, 1'b1);
    step(632, 464, 1'b1, 1'b1, 1'b1);
    checks++;
    if (rgb_o !== 12'hA5C) begin
      errors++;
      $display("FAIL freeze_pre: got %h want A5C", rgb_o);
    end
    @(negedge clk);
    draw_x   = 10'd0;
    draw_y   = 10'd0;
    hs_in    = 1'b0;
    blank_in = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (rgb_o !== 12'hA5C || vga_hs !== 1'b1) begin
      errors++;
      $display("FAIL freeze_out: rgb=%h hs=%b want A5C 1", rgb_o, vga_hs);
    end
    checks++;
    if (mif.vram_addr !== 10'd599 || mif.font_addr !== 11'h410) begin
      errors++;
      $display("FAIL freeze_addr: vram=%0d font=%h want 599 410", mif.vram_addr, mif.font_addr);
    end
    step(0, 0, 1'b1, 1'b1, 1'b1);
    step(0, 0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (rgb_o !== 12'h123) begin
      errors++;
      $display("FAIL freeze_resume: got %h want 123", rgb_o);
    end
  endtask

  task automatic test_sync();
    logic hs_hist [100];
    logic vs_hist [100];
    int   low_cnt = 0;
    for (int j = 0; j < 100; j++) begin
      hs_hist[j] = (j >= 2 && j < 98) ? 1'b0 : 1'b1;
      vs_hist[j] = (j == 10 || j == 11) ? 1'b0 : 1'b1;
      step(j % 640, 0, hs_hist[j], vs_hist[j], 1'b1);
      if (j >= 2) begin
        checks++;
        if (vga_hs !== hs_hist[j-2] || vga_vs !== vs_hist[j-2]) begin
          errors++;
          $display("FAIL sync_step%0d: hs=%b vs=%b want hs=%b vs=%b",
                   j, vga_hs, vga_vs, hs_hist[j-2], vs_hist[j-2]);
        end
        if (vga_hs === 1'b0) low_cnt++;
      end
    end
    checks++;
    if (low_cnt != 96) begin
      errors++;
      $display("FAIL sync_hs_width: got %0d want 96", low_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] c;
    cursor_en  = 1'b1;
    cursor_idx = 12'd5;
    for (int i = 0; i < 3; i++) step(42, 14, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rgb_o !== 12'hA5C || vga_hs !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre: rgb=%h hs=%b want A5C 0", rgb_o, vga_hs);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rgb_o !== 12'h000 || vga_hs !== 1'b1 || vga_vs !== 1'b1 || mif.vram_addr !== 10'd0) begin
      errors++;
      $display("FAIL rstmid_state: rgb=%h hs=%b vs=%b addr=%0d want 000 1 1 0",
               rgb_o, vga_hs, vga_vs, mif.vram_addr);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(42, 14, 1'b1, 1'b1, 1'b1);
      checks++;
      if (i < 2 && rgb_o !== 12'h000) begin
        errors++;
        $display("FAIL rstmid_flush%0d: got %h want 000", i, rgb_o);
      end else if (i == 2 && rgb_o !== 12'h123) begin
        errors++;
        $display("FAIL rstmid_resume: got %h want 123", rgb_o);
      end
    end
    vs_edges(29);
    probe(42, 14, c);
    checks++; if (c !== 12'h123) begin errors++; $display("FAIL rstmid_blink29: got %h want 123", c); end
    vs_edges(1);
    probe(42, 14, c);
    checks++; if (c !== 12'hA5C) begin errors++; $display("FAIL rstmid_blink30: got %h want A5C", c); end
  endtask

  initial begin
    reset      = 1'b1;
    pix_en     = 1'b0;
    draw_x     = '0;
    draw_y     = '0;
    hs_in      = 1'b1;
    vs_in      = 1'b1;
    blank_in   = 1'b0;
    fg_color   = '0;
    bg_color   = '0;
    cursor_en  = 1'b0;
    cursor_idx = '0;
    for (int i = 0; i < 1024; i++) vram[i] = 32'h0;
    for (int i = 0; i < 2048; i++) font[i] = 8'h0;
    vram[0]      = 32'h0000_4100;
    vram[1]      = 32'h0000_00C1;
    vram[599]    = 32'h4100_0000;
    font[11'h410] = 8'h18;

    test_reset();
    test_glyph();
    test_boundary();
    test_inverse();
    test_cursor();
    test_freeze();
    test_sync();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
